rr_burst_scheduler: RTL and testbench

Shares one downstream burst channel between NUM_CLIENTS requesters using rotating round-robin priority. Each granted requester owns the channel for a full burst of req_len+1 beats. The grant is held until the last beat handshakes, then released. It sits between the client request logic and the shared datapath and sequences that datapath beat by beat.

---
 rtl/rr_burst_scheduler.sv | 171 +++++++++++++++++
 tb/tb_rr_burst_scheduler.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/rr_burst_scheduler.sv
// rr_burst_scheduler: rotating round-robin owner of a shared burst channel.
// A granted client owns the channel for req_len+1 beats, then the pointer
// moves past it and one idle cycle separates consecutive bursts.
// Optional feature macro: RR_BURST_TIMEOUT_EN (stall timeout with abort pulse).
module rr_burst_scheduler #(
  parameter int unsigned NUM_CLIENTS = 4,
  parameter int unsigned LEN_W       = 4,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_CLIENTS-1:0]           req,
  input  logic [NUM_CLIENTS*LEN_W-1:0]     req_len,
  output logic [NUM_CLIENTS-1:0]           grant,
  output logic [$clog2(NUM_CLIENTS)-1:0]   grant_id,
  output logic                             beat_valid,
  input  logic                             beat_ready,
  output logic                             beat_last,
  output logic                             abort
);

  localparam int unsigned ID_W  = $clog2(NUM_CLIENTS);
  localparam int unsigned SUM_W = ID_W + 1;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BURST = 1'b1;

  logic [0:0]             state_q, state_d;
  logic [NUM_CLIENTS-1:0] grant_d;
  logic [ID_W-1:0]        grant_id_d;
  logic                   beat_valid_d;
  logic [LEN_W-1:0]       len_q, len_d;
  logic [LEN_W-1:0]       count_q, count_d;
  logic [ID_W-1:0]        ptr_q, ptr_d;
  logic [ID_W-1:0]        ptr_next;
  logic [ID_W-1:0]        win_id;
  logic [LEN_W-1:0]       win_len;
  logic [SUM_W-1:0]       cand;
  logic                   hs;

`ifdef RR_BURST_TIMEOUT_EN
  localparam int unsigned STALL_W = $clog2(TIMEOUT_CYC + 1);
  logic [STALL_W-1:0]     stall_q, stall_d;
  logic                   abort_d;
`endif

  assign hs        = beat_valid & beat_ready;
  assign beat_last = (state_q == BURST) && (count_q == len_q);
  assign ptr_next  = (grant_id == ID_W'(NUM_CLIENTS - 1)) ? '0 : grant_id + ID_W'(1);

  // First requesting client searching cyclically upward from the pointer
  always_comb begin
    win_id = '0;
    cand   = '0;
    for (int k = int'(NUM_CLIENTS) - 1; k >= 0; k--) begin
      cand = SUM_W'(ptr_q) + SUM_W'(k);
      if (cand >= SUM_W'(NUM_CLIENTS)) cand = cand - SUM_W'(NUM_CLIENTS);
      if (req[cand[ID_W-1:0]]) win_id = cand[ID_W-1:0];
    end
  end

  // Burst length field of the selected client
  always_comb begin
    win_len = '0;
    for (int i = 0; i < int'(NUM_CLIENTS); i++) begin
      if (ID_W'(i) == win_id) win_len = req_len[i*LEN_W +: LEN_W];
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    grant_d      = grant;
    grant_id_d   = grant_id;
    beat_valid_d = beat_valid;
    len_d        = len_q;
    count_d      = count_q;
    ptr_d        = ptr_q;
`ifdef RR_BURST_TIMEOUT_EN
    stall_d      = stall_q;
    abort_d      = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d      = BURST;
          grant_d      = NUM_CLIENTS'(1) << win_id;
          grant_id_d   = win_id;
          beat_valid_d = 1'b1;
          len_d        = win_len;
          count_d      = '0;
`ifdef RR_BURST_TIMEOUT_EN
          stall_d      = '0;
`endif
        end
      end
      BURST: begin
        if (hs) begin
`ifdef RR_BURST_TIMEOUT_EN
          stall_d = '0;
`endif
          if (beat_last) begin
            state_d      = IDLE;
            grant_d      = '0;
            grant_id_d   = '0;
            beat_valid_d = 1'b0;
            ptr_d        = ptr_next;
          end else begin
            count_d = count_q + LEN_W'(1);
          end
        end
`ifdef RR_BURST_TIMEOUT_EN
        else if (stall_q == STALL_W'(TIMEOUT_CYC)) begin
          state_d      = IDLE;
          grant_d      = '0;
          grant_id_d   = '0;
          beat_valid_d = 1'b0;
          ptr_d        = ptr_next;
          stall_d      = '0;
          abort_d      = 1'b1;
        end else begin
          stall_d = stall_q + STALL_W'(1);
        end
`endif
      end
      default: begin
        state_d      = IDLE;
        grant_d      = '0;
        grant_id_d   = '0;
        beat_valid_d = 1'b0;
      end
    endcase
  end

  // State, output and bookkeeping registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant      <= '0;
      grant_id   <= '0;
      beat_valid <= 1'b0;
      len_q      <= '0;
      count_q    <= '0;
      ptr_q      <= '0;
    end else begin
      state_q    <= state_d;
      grant      <= grant_d;
      grant_id   <= grant_id_d;
      beat_valid <= beat_valid_d;
      len_q      <= len_d;
      count_q    <= count_d;
      ptr_q      <= ptr_d;
    end
  end

`ifdef RR_BURST_TIMEOUT_EN
  // Stall counter and one-cycle abort pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      abort   <= 1'b0;
    end else begin
      stall_q <= stall_d;
      abort   <= abort_d;
    end
  end
`else
  assign abort = 1'b0;
`endif

endmodule

// File: tb/tb_rr_burst_scheduler.sv
// Randomized bench for rr_burst_scheduler against a transaction-level model.
module tb_rr_burst_scheduler;

  localparam int N  = 4;
  localparam int LW = 4;
  localparam int TO = 8;
  localparam int IW = $clog2(N);

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N*LW-1:0] req_len;
  logic [N-1:0]    grant;
  logic [IW-1:0]   grant_id;
  logic            beat_valid;
  logic            beat_ready;
  logic            beat_last;
  logic            abort;

  int errors = 0;
  int checks = 0;

  // model: owner = -1 when the channel is idle
  int owner = -1;
  int blen  = 0;
  int done  = 0;
  int ptr   = 0;
  int stall = 0;
  bit abort_m = 1'b0;

  rr_burst_scheduler #(
    .NUM_CLIENTS(N),
    .LEN_W      (LW),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_len   (req_len),
    .grant     (grant),
    .grant_id  (grant_id),
    .beat_valid(beat_valid),
    .beat_ready(beat_ready),
    .beat_last (beat_last),
    .abort     (abort)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic compare_outputs();
    logic [31:0] eg;
    eg = (owner >= 0) ? (32'd1 << owner) : 32'd0;
    check("grant",      32'(grant),      eg);
    check("grant_id",   32'(grant_id),   (owner >= 0) ? 32'(owner) : 32'd0);
    check("beat_valid", 32'(beat_valid), (owner >= 0) ? 32'd1 : 32'd0);
    check("beat_last",  32'(beat_last),  (owner >= 0 && done == blen) ? 32'd1 : 32'd0);
    check("abort",      32'(abort),      32'(abort_m));
  endtask

  // Advance the model by one clock using the inputs presented this cycle
  task automatic step();
    bit ab;
    bit found;
    ab = 1'b0;
    if (owner >= 0) begin
      if (beat_ready) begin
        stall = 0;
        if (done == blen) begin
          ptr   = (owner + 1) % N;
          owner = -1;
        end else begin
          done++;
        end
      end else begin
`ifdef RR_BURST_TIMEOUT_EN
        if (stall == TO) begin
          ab    = 1'b1;
          ptr   = (owner + 1) % N;
          owner = -1;
          stall = 0;
        end else begin
          stall++;
        end
`endif
      end
    end else if (req != '0) begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        if (!found && req[(ptr + k) % N]) begin
          owner = (ptr + k) % N;
          found = 1'b1;
        end
      end
      blen  = int'(req_len[owner*LW +: LW]);
      done  = 0;
      stall = 0;
    end
    abort_m = ab;
  endtask

  task automatic drive(input int ready_pct, input bit all_req, input int len_max);
    for (int i = 0; i < N; i++) begin
      if (all_req) req[i] = 1'b1;
      else if (!req[i]) req[i] = ($urandom % 3 == 0);
      else if (owner == i && ($urandom % 2 == 1)) req[i] = 1'b0;
      req_len[i*LW +: LW] = LW'($urandom_range(0, len_max));
    end
    beat_ready = (int'($urandom % 100) < ready_pct);
  endtask

  task automatic run(input int n, input int ready_pct, input bit all_req, input int len_max);
    repeat (n) begin
      @(negedge clk);
      compare_outputs();
      drive(ready_pct, all_req, len_max);
      step();
    end
  endtask

  // Asynchronous reset landing between clock edges
  task automatic mid_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_grant",      32'(grant),      32'd0);
    check("rst_grant_id",   32'(grant_id),   32'd0);
    check("rst_beat_valid", 32'(beat_valid), 32'd0);
    check("rst_beat_last",  32'(beat_last),  32'd0);
    check("rst_abort",      32'(abort),      32'd0);
    owner = -1; ptr = 0; stall = 0; done = 0; abort_m = 1'b0;
    req = '0;
    beat_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n      = 1'b0;
    req        = '0;
    req_len    = '0;
    beat_ready = 1'b0;
    repeat (2) @(negedge clk);
    compare_outputs();
    rst_n = 1'b1;

    run(300, 70, 1'b0, 3);
    run(40, 100, 1'b1, 0);
    mid_reset();
    run(300, 50, 1'b0, 15);
    mid_reset();
    run(20, 100, 1'b0, 4);
    run(120, 0, 1'b0, 2);
    run(200, 80, 1'b0, 5);
    mid_reset();
    run(60, 100, 1'b1, 15);
    run(100, 60, 1'b0, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
